// File: rtl/pla_seq_eval.sv
// Sequential PLA evaluator: a programmable AND/OR term table is scanned TPC
// terms per cycle against a latched input vector, producing an OR-merged result and hit count.
module pla_seq_eval #(
  parameter int NI  = 15,
  parameter int NO  = 11,
  parameter int NT  = 32,
  parameter int TPC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  output logic                    cfg_ready,
  input  logic [$clog2(NT)-1:0]   cfg_addr,
  input  logic                    cfg_en,
  input  logic [NI-1:0]           cfg_mask,
  input  logic [NI-1:0]           cfg_val,
  input  logic [NO-1:0]           cfg_or,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NI-1:0]           x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NO-1:0]           z,
  output logic [$clog2(NT):0]     hit_cnt
);

  localparam int AW = $clog2(NT);
  localparam int CW = AW + 1;
  localparam int NG = NT / TPC;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t state_q, state_d;

  logic          tbl_en   [NT];
  logic [NI-1:0] tbl_mask [NT];
  logic [NI-1:0] tbl_val  [NT];
  logic [NO-1:0] tbl_or   [NT];

  logic [NI-1:0] x_lat;
  logic [NO-1:0] acc;
  logic [CW-1:0] cnt;
  logic [GW-1:0] idx;
  logic          fin;

  logic [NO-1:0] grp_or;
  logic [CW-1:0] grp_hits;
  logic [AW-1:0] sel;
  logic          wr_go;
  logic          acc_go;

  function automatic logic term_hit(input logic en, input logic [NI-1:0] m,
                                    input logic [NI-1:0] v, input logic [NI-1:0] xv);
    return en && (((xv ^ v) & m) == '0);
  endfunction

  assign wr_go  = cfg_we & cfg_ready;
  assign acc_go = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        in_ready  = 1'b1;
        if (in_valid) state_d = EVAL;
      end
      EVAL:    if (fin) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Term table; a write in the accept cycle lands before the first group is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NT; i++) begin
        tbl_en[i]   <= 1'b0;
        tbl_mask[i] <= '0;
        tbl_val[i]  <= '0;
        tbl_or[i]   <= '0;
      end
    end else if (wr_go) begin
      tbl_en[cfg_addr]   <= cfg_en;
      tbl_mask[cfg_addr] <= cfg_mask;
      tbl_val[cfg_addr]  <= cfg_val;
      tbl_or[cfg_addr]   <= cfg_or;
    end
  end

  // Stage: evaluate the TPC terms of the current group against the latched input
  always_comb begin
    grp_or   = '0;
    grp_hits = '0;
    sel      = '0;
    for (int t = 0; t < TPC; t++) begin
      sel = AW'(int'(idx) * TPC + t);
      if (term_hit(tbl_en[sel], tbl_mask[sel], tbl_val[sel], x_lat)) begin
        grp_or   = grp_or | tbl_or[sel];
        grp_hits = grp_hits + CW'(1);
      end
    end
  end

  // Stage: accumulate groups, then publish the result one cycle after the last group
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat     <= '0;
      acc       <= '0;
      cnt       <= '0;
      idx       <= '0;
      fin       <= 1'b0;
      z         <= '0;
      hit_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_go) begin
            x_lat <= x;
            acc   <= '0;
            cnt   <= '0;
            idx   <= '0;
            fin   <= 1'b0;
          end
        end
        EVAL: begin
          if (fin) begin
            z         <= acc;
            hit_cnt   <= cnt;
            out_valid <= 1'b1;
            fin       <= 1'b0;
          end else begin
            acc <= acc | grp_or;
            cnt <= cnt + grp_hits;
            if (idx == GW'(NG - 1)) begin
              idx <= '0;
              fin <= 1'b1;
            end else begin
              idx <= idx + GW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pla_seq_eval.sv
// Directed bench for pla_seq_eval: table-driven term vectors plus hand-written
// sequences for backpressure, simultaneous write/accept and mid-evaluation reset.
module tb_pla_seq_eval;

  localparam int NI  = 15;
  localparam int NO  = 11;
  localparam int NT  = 32;
  localparam int TPC = 4;
  localparam int AW  = $clog2(NT);
  localparam int CW  = AW + 1;
  localparam int LAT = NT / TPC + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr = '0;
  logic          cfg_en = 1'b0;
  logic [NI-1:0] cfg_mask = '0;
  logic [NI-1:0] cfg_val = '0;
  logic [NO-1:0] cfg_or = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NI-1:0] x = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NO-1:0] z;
  logic [CW-1:0] hit_cnt;

  int checks = 0;
  int errors = 0;

  pla_seq_eval #(.NI(NI), .NO(NO), .NT(NT), .TPC(TPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_or(cfg_or),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic          en;
    logic [NI-1:0] mask;
    logic [NI-1:0] val;
    logic [NO-1:0] orv;
    logic [NI-1:0] xv;
    logic [NO-1:0] ez;
    logic [CW-1:0] eh;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic en, input logic [NI-1:0] m,
                             input logic [NI-1:0] v, input logic [NO-1:0] o);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_en = en; cfg_mask = m; cfg_val = v; cfg_or = o;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Offer x, let it be accepted, then scramble x so only the latched copy matters.
  task automatic start(input logic [NI-1:0] xv);
    @(negedge clk);
    in_valid = 1'b1; x = xv;
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; x = ~xv;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 40) begin
      lat++;
      @(posedge clk); #1;
      if (out_valid) break;
    end
    if (!out_valid) begin
      errors++;
      checks++;
      $display("FAIL out_valid_timeout actual 0 required 1");
    end
  endtask

  task automatic finish_out(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_ovalid_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run(input string nm, input logic [NI-1:0] xv,
                     input logic [NO-1:0] ez, input logic [CW-1:0] eh);
    int lat;
    start(xv);
    wait_out(lat);
    chk({nm, "_lat"}, lat, LAT);
    chk({nm, "_z"}, {21'b0, z}, {21'b0, ez});
    chk({nm, "_hits"}, {26'b0, hit_cnt}, {26'b0, eh});
    finish_out(nm);
  endtask

  initial begin
    int  lat;
    bit  seen;
    logic [NO-1:0] zhold;

    //      wr addr en mask      val       or       x         ez       eh
    vecs[0] = '{0, 0,  0, 15'h0,    15'h0,    11'h0,   15'h7FFF, 11'h000, 0};
    vecs[1] = '{1, 5,  1, 15'h0003, 15'h0001, 11'h004, 15'h0001, 11'h004, 1};
    vecs[2] = '{0, 0,  0, 15'h0,    15'h0,    11'h0,   15'h0003, 11'h000, 0};
    vecs[3] = '{0, 0,  0, 15'h0,    15'h0,    11'h0,   15'h7FFD, 11'h004, 1};
    vecs[4] = '{1, 0,  1, 15'h0,    15'h0,    11'h001, 15'h1234, 11'h001, 1};
    vecs[5] = '{1, 31, 1, 15'h0,    15'h0,    11'h400, 15'h1234, 11'h401, 2};
    vecs[6] = '{0, 0,  0, 15'h0,    15'h0,    11'h0,   15'h0001, 11'h405, 3};
    vecs[7] = '{1, 5,  0, 15'h0003, 15'h0001, 11'h004, 15'h0001, 11'h401, 2};
    vecs[8] = '{1, 10, 1, 15'h7FFF, 15'h2AAA, 11'h080, 15'h2AAA, 11'h481, 3};
    vecs[9] = '{0, 0,  0, 15'h0,    15'h0,    11'h0,   15'h2AAB, 11'h401, 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovalid", {31'b0, out_valid}, 32'd0);
    chk("rst_z", {21'b0, z}, 32'd0);
    chk("rst_hits", {26'b0, hit_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);

    // out_ready while idle does nothing
    @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_oready_ovalid", {31'b0, out_valid}, 32'd0);
    chk("idle_oready_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr)
        write_entry(vecs[i].addr, vecs[i].en, vecs[i].mask, vecs[i].val, vecs[i].orv);
      run($sformatf("v%0d", i), vecs[i].xv, vecs[i].ez, vecs[i].eh);
    end

    // Backpressure: result held for 20 cycles while a write to entry 0 is attempted
    start(15'h0000);
    wait_out(lat);
    chk("bp_lat", lat, LAT);
    zhold = z;
    chk("bp_z", {21'b0, z}, 32'h401);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = '0; cfg_en = 1'b0; cfg_mask = '0; cfg_val = '0; cfg_or = '0;
      @(posedge clk); #1;
      chk($sformatf("bp_hold_z%0d", c), {21'b0, z}, {21'b0, zhold});
      chk($sformatf("bp_hold_ov%0d", c), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_in_ready%0d", c), {30'b0, in_ready, cfg_ready}, 32'd0);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    finish_out("bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_single_result", {31'b0, out_valid}, 32'd0);
    run("bp_entry0_kept", 15'h0000, 11'h401, 2);

    // Write entry 3 in the same cycle the input is accepted
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 5'd3; cfg_en = 1'b1; cfg_mask = '0; cfg_val = '0; cfg_or = 11'h010;
    in_valid = 1'b1; x = 15'h0000;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0; x = 15'h7FFF;
    wait_out(lat);
    chk("wa_lat", lat, LAT);
    chk("wa_z", {21'b0, z}, 32'h411);
    chk("wa_hits", {26'b0, hit_cnt}, 32'd3);
    finish_out("wa");

    // Reset three cycles into evaluation
    start(15'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_ovalid", {31'b0, out_valid}, 32'd0);
    chk("mrst_z", {21'b0, z}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mrst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mrst_no_result", {31'b0, seen}, 32'd0);
    run("mrst_cleared", 15'h0000, 11'h000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
